// File: rtl/jtframe_rom_pkg.sv
// Shared types and helpers for the N-slot SDRAM ROM arbiter.
//   st_t       : arbiter FSM states
//   SDRAM_AW/DW: SDRAM word address / data widths
//   byte_lane  : picks the byte half of a cached word for byte-wide slots
package jtframe_rom_pkg;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DATA
  } st_t;

  // Word slots pass the full word; byte slots return the addressed byte
  // zero-extended, low byte at even addresses.
  function automatic logic [SDRAM_DW-1:0] byte_lane(input logic [SDRAM_DW-1:0] d,
                                                    input logic dw8,
                                                    input logic a0);
    if (!dw8) return d;
    return a0 ? {8'd0, d[15:8]} : {8'd0, d[7:0]};
  endfunction

endpackage

// File: rtl/jtframe_rom_slotc.sv
// One-word cache for a single ROM client slot.
//   clk/rst     : clock, async active-high reset
//   inv_i       : invalidate (ROM download); also suppresses ok
//   cs_i/addr_i : client request level and address
//   fill_*      : write port from the arbiter when this slot's fetch returns
//   waddr_o     : SDRAM word address (byte slots drop addr[0])
//   hit_o       : combinational cache hit for the current address
//   ok_o/dout_o : registered client outputs
module jtframe_rom_slotc
  import jtframe_rom_pkg::*;
#(
  parameter int SAW = 22,
  parameter bit DW8 = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inv_i,
  input  logic                cs_i,
  input  logic [SAW-1:0]      addr_i,
  input  logic                fill_en_i,
  input  logic [SAW-1:0]      fill_tag_i,
  input  logic [SDRAM_DW-1:0] fill_data_i,
  output logic [SAW-1:0]      waddr_o,
  output logic                hit_o,
  output logic                ok_o,
  output logic [SDRAM_DW-1:0] dout_o
);

  logic                valid_q;
  logic [SAW-1:0]      tag_q;
  logic [SDRAM_DW-1:0] data_q;
  logic                ok_q;
  logic [SDRAM_DW-1:0] dout_q;
  logic                ok_d;

  assign waddr_o = DW8 ? (addr_i >> 1) : addr_i;
  assign hit_o   = cs_i & valid_q & (tag_q == waddr_o);
  assign ok_d    = hit_o & ~inv_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      // Invalidation beats a same-cycle fill so a download never leaves
      // stale data behind.
      if (inv_i) begin
        valid_q <= 1'b0;
      end else if (fill_en_i) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag_i;
        data_q  <= fill_data_i;
      end
      ok_q <= ok_d;
      if (ok_d) dout_q <= byte_lane(data_q, DW8, addr_i[0]);
    end
  end

  assign ok_o   = ok_q;
  assign dout_o = dout_q;

endmodule

// File: rtl/jtframe_rom_nslot.sv
// N-slot SDRAM ROM read arbiter with a one-word cache per slot.
//   clk, rst (async high), downloading (invalidate + abort)
//   slot_cs/slot_addr/slot_ok/slot_dout : per-slot client interface
//   sdram_req/ack/addr, data_rdy/data_read : SDRAM controller interface
//   data_dst : advisory only, not used for latching
// Optional macro JTFRAME_ROM_RR_EN: round-robin arbitration starting after
// the last winner; otherwise fixed priority with the lowest slot first.
module jtframe_rom_nslot
  import jtframe_rom_pkg::*;
#(
  parameter int                  SLOTS   = 8,
  parameter int                  SAW     = 22,
  parameter logic [SLOTS-1:0]    DW8     = '0,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   downloading,
  input  logic [SLOTS-1:0]       slot_cs,
  input  logic [SLOTS*SAW-1:0]   slot_addr,
  output logic [SLOTS-1:0]       slot_ok,
  output logic [SLOTS*16-1:0]    slot_dout,
  output logic                   sdram_req,
  input  logic                   sdram_ack,
  input  logic                   data_dst,
  input  logic                   data_rdy,
  output logic [SDRAM_AW-1:0]    sdram_addr,
  input  logic [SDRAM_DW-1:0]    data_read
);

  localparam int WW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  st_t                              st_q, st_d;
  logic                             req_q, req_d;
  logic [SDRAM_AW-1:0]              addr_q, addr_d;
  logic [WW-1:0]                    win_q, win_d;
  logic [SAW-1:0]                   tag_q, tag_d;
  logic                             fill_en;
  logic                             busy;
  logic                             found;
  logic [WW-1:0]                    pick;

  logic [SLOTS-1:0][SAW-1:0]        waddr;
  logic [SLOTS-1:0][SDRAM_AW-1:0]   saddr;
  logic [SLOTS-1:0]                 hit, pend, fill_sel;

  logic unused_dst;
  assign unused_dst = data_dst;

  assign busy = (st_q != IDLE);

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    jtframe_rom_slotc #(.SAW(SAW), .DW8(DW8[g])) u_slot (
      .clk        (clk),
      .rst        (rst),
      .inv_i      (downloading),
      .cs_i       (slot_cs[g]),
      .addr_i     (slot_addr[SAW*g +: SAW]),
      .fill_en_i  (fill_sel[g]),
      .fill_tag_i (tag_q),
      .fill_data_i(data_read),
      .waddr_o    (waddr[g]),
      .hit_o      (hit[g]),
      .ok_o       (slot_ok[g]),
      .dout_o     (slot_dout[16*g +: 16])
    );
    // Offset add wraps modulo the SDRAM address space.
    assign saddr[g]    = SDRAM_AW'(waddr[g]) + OFFSETS[22*g +: 22];
    assign pend[g]     = slot_cs[g] & ~hit[g] & ~(busy & (win_q == WW'(g)));
    assign fill_sel[g] = fill_en & (win_q == WW'(g));
  end

`ifdef JTFRAME_ROM_RR_EN
  logic [WW-1:0] last_q, last_d;
  logic [WW-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      cand = WW'((int'(last_q) + 1 + k) % SLOTS);
      if (!found && pend[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= WW'(SLOTS - 1);
    else     last_q <= last_d;
  end
`else
  always_comb begin
    found = 1'b0;
    pick  = '0;
    // Descending scan: the lowest pending index is assigned last and wins.
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (pend[k]) begin
        found = 1'b1;
        pick  = WW'(k);
      end
    end
  end
`endif

  always_comb begin
    st_d    = st_q;
    req_d   = req_q;
    addr_d  = addr_q;
    win_d   = win_q;
    tag_d   = tag_q;
    fill_en = 1'b0;
`ifdef JTFRAME_ROM_RR_EN
    last_d  = last_q;
`endif
    if (downloading) begin
      // Abandon any outstanding transaction; caches clear in the slots.
      st_d  = IDLE;
      req_d = 1'b0;
    end else begin
      case (st_q)
        IDLE: if (found) begin
          st_d   = WAIT_ACK;
          req_d  = 1'b1;
          addr_d = saddr[pick];
          win_d  = pick;
          tag_d  = waddr[pick];
`ifdef JTFRAME_ROM_RR_EN
          last_d = pick;
`endif
        end
        WAIT_ACK: if (sdram_ack) begin
          st_d  = WAIT_DATA;
          req_d = 1'b0;
        end
        WAIT_DATA: if (data_rdy) begin
          // Fill with the tag captured at selection, even if the client
          // has since moved on; it simply re-misses.
          fill_en = 1'b1;
          st_d    = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
      win_q  <= '0;
      tag_q  <= '0;
    end else begin
      st_q   <= st_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      win_q  <= win_d;
      tag_q  <= tag_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jtframe_rom_nslot.sv
module tb_jtframe_rom_nslot;

  logic        clk = 1'b0;
  logic        rst, downloading, sdram_ack, data_dst, data_rdy;
  logic [3:0]  slot_cs;
  logic [87:0] slot_addr;
  logic [3:0]  slot_ok;
  logic [63:0] slot_dout;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic [15:0] data_read;
  int          total = 0;
  int          bad   = 0;

  // slot0 word @0, slot1 byte @0x5000, slot2 word @0x3FFFFF, slot3 word @0x1000
  jtframe_rom_nslot #(
    .SLOTS  (4),
    .SAW    (22),
    .DW8    (4'b0010),
    .OFFSETS({22'h001000, 22'h3FFFFF, 22'h005000, 22'h000000})
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .downloading(downloading),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_dout  (slot_dout),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_dst   (data_dst),
    .data_rdy   (data_rdy),
    .sdram_addr (sdram_addr),
    .data_read  (data_read)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [21:0] a);
    slot_addr[22*i +: 22] = a;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 30 && !sdram_req; k++) @(negedge clk);
  endtask

  // Controller model: accept the request, return one word a cycle later.
  task automatic serve(input logic [21:0] ea, input logic [15:0] d, input string tag);
    wait_req();
    chk({tag, "_req"}, 64'(sdram_req), 64'd1);
    chk({tag, "_addr"}, 64'(sdram_addr), 64'(ea));
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    chk({tag, "_reqlow"}, 64'(sdram_req), 64'd0);
    data_rdy  = 1'b1;
    data_dst  = 1'b1;
    data_read = d;
    @(negedge clk);
    data_rdy  = 1'b0;
    data_dst  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; sdram_ack = 1'b0; data_dst = 1'b0;
    data_rdy = 1'b0; slot_cs = '0; slot_addr = '0; data_read = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_req",  64'(sdram_req),  64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_ok",   64'(slot_ok),    64'd0);
    chk("rst_dout", slot_dout,       64'd0);
    rst = 1'b0;

    // Single miss then hits on a byte slot
    set_addr(1, 22'h3); slot_cs = 4'b0010;
    serve(22'h005001, 16'hABCD, "miss1");
    @(negedge clk);
    chk("hit1_ok",   64'(slot_ok[1]),       64'd1);
    chk("hit1_dout", 64'(slot_dout[31:16]), 64'h00AB);
    set_addr(1, 22'h2);
    @(negedge clk);
    chk("hit2_dout", 64'(slot_dout[31:16]), 64'h00CD);
    chk("hit2_ok",   64'(slot_ok[1]),       64'd1);
    chk("hit2_noreq", 64'(sdram_req),       64'd0);
    slot_cs = 4'b0000;
    @(negedge clk);
    chk("cs0_ok", 64'(slot_ok[1]), 64'd0);

    // Address change after ack: old tag filled, new address re-fetched
    set_addr(0, 22'h100); slot_cs = 4'b0001;
    wait_req();
    chk("mid_addr", 64'(sdram_addr), 64'h100);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; set_addr(0, 22'h200);
    data_rdy = 1'b1; data_read = 16'h1111;
    @(negedge clk);
    data_rdy = 1'b0;
    chk("mid_ok0", 64'(slot_ok[0]), 64'd0);
    serve(22'h000200, 16'h2222, "refetch");
    @(negedge clk);
    chk("mid_ok1",  64'(slot_ok[0]),       64'd1);
    chk("mid_dout", 64'(slot_dout[15:0]),  64'h2222);

    // Contention between slots 0 and 3 (last winner is slot 0)
    set_addr(0, 22'h300); set_addr(3, 22'h10); slot_cs = 4'b1001;
`ifdef JTFRAME_ROM_RR_EN
    serve(22'h001010, 16'h4444, "cont_s3");
    serve(22'h000300, 16'h3333, "cont_s0");
`else
    serve(22'h000300, 16'h3333, "cont_s0");
    serve(22'h001010, 16'h4444, "cont_s3");
`endif
    @(negedge clk);
    chk("cont_ok",    64'(slot_ok),           64'b1001);
    chk("cont_dout0", 64'(slot_dout[15:0]),   64'h3333);
    chk("cont_dout3", 64'(slot_dout[63:48]),  64'h4444);

    // Offset wrap on slot 2, then download abort during WAIT_DATA
    set_addr(2, 22'h2); slot_cs = 4'b0101;
    wait_req();
    chk("wrap_addr", 64'(sdram_addr), 64'h000001);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; downloading = 1'b1;
    data_rdy = 1'b1; data_read = 16'hDEAD;
    @(negedge clk);
    data_rdy = 1'b0;
    chk("dl_req", 64'(sdram_req), 64'd0);
    chk("dl_ok",  64'(slot_ok),   64'd0);
    @(negedge clk); @(negedge clk);
    chk("dl_req2", 64'(sdram_req), 64'd0);
    chk("dl_ok2",  64'(slot_ok),   64'd0);
    downloading = 1'b0;
    serve(22'h000300, 16'h5555, "dl_re0");
    serve(22'h000001, 16'h6666, "dl_re2");
    @(negedge clk);
    chk("dl_ok3",   64'(slot_ok),          64'b0101);
    chk("dl_dout0", 64'(slot_dout[15:0]),  64'h5555);
    chk("dl_dout2", 64'(slot_dout[47:32]), 64'h6666);

    // Async reset while waiting for ack
    set_addr(1, 22'h10); slot_cs = 4'b0011;
    wait_req();
    chk("ar_addr",  64'(sdram_addr), 64'h005008);
    chk("ar_preok", 64'(slot_ok[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_req",  64'(sdram_req),  64'd0);
    chk("ar_ok",   64'(slot_ok),    64'd0);
    chk("ar_addr0", 64'(sdram_addr), 64'd0);
    #1 rst = 1'b0;
    serve(22'h000300, 16'h8888, "ar_s0");
    serve(22'h005008, 16'h9999, "ar_s1");
    @(negedge clk);
    chk("ar_ok2",   64'(slot_ok),           64'b0011);
    chk("ar_dout0", 64'(slot_dout[15:0]),   64'h8888);
    chk("ar_dout1", 64'(slot_dout[31:16]),  64'h0099);

    // Stray data_rdy while idle must not touch any cache
    data_rdy = 1'b1; data_read = 16'hBEEF;
    @(negedge clk);
    data_rdy = 1'b0;
    @(negedge clk);
    chk("stray_dout1", 64'(slot_dout[31:16]), 64'h0099);
    chk("stray_dout0", 64'(slot_dout[15:0]),  64'h8888);
    chk("stray_req",   64'(sdram_req),        64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
